// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship board overlay.
// Holds the grid geometry, cell-state encoding and marker colours.
package battleship_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned GRID_X0 = 142;
  localparam int unsigned GRID_Y0 = 71;
  localparam int unsigned CELL_PX = 34;
  localparam int unsigned NCELL   = 10;
  localparam int unsigned NCELLS  = NCELL * NCELL;
  localparam int unsigned INSET   = 8;
  localparam int unsigned H_LAST  = 639;
  localparam int unsigned V_LAST  = 479;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned RGB_W   = 16;

  localparam logic [RGB_W-1:0] COL_SHIP = 16'h8410;
  localparam logic [RGB_W-1:0] COL_MISS = 16'hFFFF;
  localparam logic [RGB_W-1:0] COL_HIT  = 16'hF800;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIP  = 2'd1,
    MISS  = 2'd2,
    HIT   = 2'd3
  } cell_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ovl_state_t;

  // Flat array index of a cell; callers guarantee row/col are in range.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return IDX_W'(32'(row) * NCELL + 32'(col));
  endfunction

  function automatic logic [RGB_W-1:0] marker_rgb(input cell_state_t st);
    logic [RGB_W-1:0] rgb;
    rgb = '0;
    case (st)
      SHIP:    rgb = COL_SHIP;
      MISS:    rgb = COL_MISS;
      HIT:     rgb = COL_HIT;
      default: rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/cell_locator.sv
// Maps a screen coordinate to a grid cell and the offset inside that cell.
// Pure combinational; a constant comparator chain replaces division.
module cell_locator
  import battleship_pkg::*;
#(
  parameter int unsigned X0 = GRID_X0,
  parameter int unsigned Y0 = GRID_Y0
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_on_grid,
  output logic [3:0]         o_row,
  output logic [3:0]         o_col,
  output logic [5:0]         o_sx,
  output logic [5:0]         o_sy
);

  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;

  // Bit COORD_W set means the coordinate lies left of / above the grid.
  assign w_dx = {1'b0, i_x} - (COORD_W+1)'(X0);
  assign w_dy = {1'b0, i_y} - (COORD_W+1)'(Y0);

  always_comb begin
    o_col = '0;
    o_row = '0;
    for (int unsigned k = 1; k <= NCELL; k++) begin
      if (!w_dx[COORD_W] && (w_dx >= (COORD_W+1)'(k * CELL_PX))) o_col = o_col + 4'd1;
      if (!w_dy[COORD_W] && (w_dy >= (COORD_W+1)'(k * CELL_PX))) o_row = o_row + 4'd1;
    end
  end

  assign o_sx = 6'(w_dx - (COORD_W+1)'(32'(o_col) * CELL_PX));
  assign o_sy = 6'(w_dy - (COORD_W+1)'(32'(o_row) * CELL_PX));

  assign o_on_grid = !w_dx[COORD_W] && !w_dy[COORD_W] &&
                     (o_col < 4'(NCELL)) && (o_row < 4'(NCELL));

endmodule

// File: rtl/board_overlay.sv
// Per-cell marker layer for the 10x10 board: shadow/display cell arrays,
// write/clear FSM and a one-cycle pixel path feeding the PPU mux.
module board_overlay
  import battleship_pkg::*;
(
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [3:0]         wr_row,
  input  logic [3:0]         wr_col,
  input  logic [1:0]         wr_state,
  input  logic               clr_req,
  input  logic [COORD_W-1:0] next_x,
  input  logic [COORD_W-1:0] next_y,
  output logic               ov_valid,
  output logic [RGB_W-1:0]   ov_rgb,
  output logic               busy
);

  ovl_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_wr_ready;
  logic             r_busy;
  logic             r_ov_valid;
  logic [RGB_W-1:0] r_ov_rgb;
  cell_state_t      r_shadow  [NCELLS];
  cell_state_t      r_display [NCELLS];

  logic             w_on_grid;
  logic [3:0]       w_row;
  logic [3:0]       w_col;
  logic [5:0]       w_sx;
  logic [5:0]       w_sy;
  logic             w_wr_in_range;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_commit;
  logic             w_blank;
  logic             w_inside;
  logic [IDX_W-1:0] w_pix_idx;
  cell_state_t      w_pix_state;

  cell_locator u_cell_locator (
    .i_x       (next_x),
    .i_y       (next_y),
    .o_on_grid (w_on_grid),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_sx      (w_sx),
    .o_sy      (w_sy)
  );

  assign w_wr_in_range = (wr_row < 4'(NCELL)) && (wr_col < 4'(NCELL));
  assign w_wr_idx      = cell_idx(wr_row, wr_col);
  assign w_commit      = (next_x == COORD_W'(H_LAST)) && (next_y == COORD_W'(V_LAST));

  // Write/clear FSM; wr_ready and busy are registered from the next state.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < int'(NCELLS); i++) r_shadow[i] <= EMPTY;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr_ready <= 1'b1;
          r_busy     <= 1'b0;
          if (clr_req) begin
            r_state    <= CLEAR;
            r_idx      <= '0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else if (wr_valid && r_wr_ready && w_wr_in_range) begin
            r_shadow[w_wr_idx] <= cell_state_t'(wr_state);
          end
        end
        CLEAR: begin
          r_shadow[r_idx] <= EMPTY;
          if (r_idx == IDX_W'(NCELLS - 1)) begin
            r_state    <= IDLE;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Frame-boundary commit sees shadow values from before this edge's update.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCELLS); i++) r_display[i] <= EMPTY;
    end else if (w_commit) begin
      for (int i = 0; i < int'(NCELLS); i++) r_display[i] <= r_shadow[i];
    end
  end

  assign w_blank   = (next_x > COORD_W'(H_LAST)) || (next_y > COORD_W'(V_LAST));
  assign w_inside  = w_on_grid && !w_blank &&
                     (w_sx >= 6'(INSET)) && (w_sx <= 6'(CELL_PX - 1 - INSET)) &&
                     (w_sy >= 6'(INSET)) && (w_sy <= 6'(CELL_PX - 1 - INSET));
  assign w_pix_idx   = w_on_grid ? cell_idx(w_row, w_col) : '0;
  assign w_pix_state = r_display[w_pix_idx];

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      r_ov_valid <= 1'b0;
      r_ov_rgb   <= '0;
    end else begin
      r_ov_valid <= w_inside && (w_pix_state != EMPTY);
      r_ov_rgb   <= w_inside ? marker_rgb(w_pix_state) : '0;
    end
  end

  assign wr_ready = r_wr_ready;
  assign busy     = r_busy;
  assign ov_valid = r_ov_valid;
  assign ov_rgb   = r_ov_rgb;

endmodule

// File: doc/board_overlay.md
Name: board_overlay

Overview:
- Per-cell marker layer for the 10x10 Battleship grid. Sits directly upstream of the PPU pixel mux.
- Game logic writes cell states (empty/ship/miss/hit) through a ready/valid port into a shadow array. Shadow state is committed to a display array once per frame, at the frame boundary.
- For each next_x/next_y from the VGA timing generator, the block returns an RGB565 marker colour one cycle later. This aligns with the board ROM output and curr_x/curr_y, so the PPU overrides the ROM pixel whenever ov_valid=1.

Parameters:
- GRID_X0, 142, screen x of first pixel of cell column 0 (board origin 141 plus 1 px border)
- GRID_Y0, 71, screen y of first pixel of cell row 0
- CELL_PX, 34, cell pitch in pixels, both axes
- NCELL, 10, cells per row and per column
- INSET, 8, marker inset from each cell edge in pixels
- H_LAST, 639, last visible x
- V_LAST, 479, last visible y

Ports:
- vga_clk  in  1  25 MHz pixel clock
- rst_n  in  1  synchronous active-low reset
- wr_valid  in  1  cell write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_row  in  4  cell row 0..9
- wr_col  in  4  cell column 0..9
- wr_state  in  2  0 empty, 1 ship, 2 miss, 3 hit
- clr_req  in  1  one-cycle pulse: clear whole shadow array to empty
- next_x  in  10  x of next pixel, from VGA timing generator
- next_y  in  10  y of next pixel
- ov_valid  out  1  marker pixel present (registered)
- ov_rgb  out  16  RGB565 marker colour (registered)
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (sampled on vga_clk with rst_n=0): all 100 shadow and display entries = 0; FSM = IDLE; ov_valid=0; ov_rgb=0; wr_ready=0 during reset, 1 the first cycle after; busy=0.
- A reset asserted mid-sweep aborts the sweep immediately.
- FSM IDLE: wr_ready=1. A handshake writes shadow[wr_row*10+wr_col] <= wr_state on that edge.
  - Out-of-range row or column (>9): handshake completes, no entry changes.
  - clr_req in IDLE: go to CLEAR with idx=0. If a write handshake occurs in the same cycle, the write is dropped (clear wins).
- FSM CLEAR: wr_ready=0, busy=1. Each cycle: shadow[idx] <= 0, idx++. After idx=99, return to IDLE.
  - Sweep length is exactly 100 cycles. clr_req during CLEAR is ignored.
- Commit: when next_x==H_LAST and next_y==V_LAST, display <= shadow (all entries, one edge).
  - Commit uses shadow values before any write or clear step landing on that same edge; those appear next frame.
  - A frame boundary mid-sweep commits a partially cleared array; this is accepted behaviour.
- Pixel path, latency exactly 1 cycle:
  - dx = next_x - GRID_X0, dy = next_y - GRID_Y0, computed 11-bit signed. Negative values mean off-grid.
  - col = number of k in 1..NCELL with dx >= k*CELL_PX (constant comparator chain, no divider). row likewise from dy.
  - sx = dx - col*CELL_PX, sy = dy - row*CELL_PX.
  - inside = dx>=0 && dy>=0 && col<NCELL && row<NCELL && INSET<=sx<=CELL_PX-1-INSET && INSET<=sy<=CELL_PX-1-INSET.
  - Next edge: ov_valid <= inside && display[row*10+col]!=0.
  - ov_rgb: ship 16'h8410, miss 16'hFFFF, hit 16'hF800. ov_rgb=0 whenever ov_valid=0.
  - x>H_LAST or y>V_LAST (blanking) always yields ov_valid=0.

Decomposition:
- Package battleship_pkg:
  - enum cell_state_t {EMPTY, SHIP, MISS, HIT}
  - RGB565 constants COL_SHIP, COL_MISS, COL_HIT
  - enum ovl_state_t {IDLE, CLEAR}
- Sub-module cell_locator: combinational next_x/next_y to {on_grid, row, col, sx, sy}. Reusable later for cursor highlighting.
- State arrays, FSM and output registers stay in board_overlay.

Test Plan:
- Reset: hold rst_n=0 3 cycles -> ov_valid=0, ov_rgb=0, busy=0. Then release -> wr_ready=1 next cycle; full frame with no writes gives ov_valid=0 everywhere.
- Write row 2, col 3, state HIT in frame N -> no marker in frame N. In frame N+1, pixel (252,147) gives ov_valid=1, ov_rgb=F800 one cycle after presentation. Pixel (251,147) gives ov_valid=0 (sx=7<INSET).
- Grid edge: write row 9, col 9, SHIP; commit -> (473,402) gives 8410. (474,402) gives 0. (482,400) (border) gives 0.
- Out-of-range: write row 10, col 0, MISS -> handshake completes, no pixel ever lit. Write row 0, col 0, MISS -> (150,79) gives FFFF.
- Clear: fill 5 cells, pulse clr_req with a concurrent write -> busy=1 and wr_ready=0 for exactly 100 cycles, concurrent write dropped. After next commit, no markers.
- Commit race: write cell (0,0) HIT on the exact edge where next_x=639 and next_y=479 -> next frame shows no marker at (150,79); the frame after shows F800.
